bit_serializer: RTL and testbench

//  Parallel-to-serial front end for the sequence-detector (sqd) FSM.

---
 rtl/sqd_pkg.sv | 13 +
 rtl/bit_hold_reg.sv | 40 ++++
 rtl/bit_serializer.sv | 125 ++++++++++++
 tb/tb_bit_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqd_pkg.sv
// Shared definitions for the sequence-detector front end: serializer state
// encoding and the default word width used by the serializer and detector bench.
package sqd_pkg;

  localparam int SQD_WORD_W = 6;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_SHIFT = 2'b01,
    SER_GAP   = 2'b10
  } ser_state_t;

endpackage

// File: rtl/bit_hold_reg.sv
// Single-entry holding register between the input handshake and the shifter.
// Writes only happen while empty and reads only while full, so they never collide.
module bit_hold_reg
  import sqd_pkg::*;
#(
  parameter int WIDTH = SQD_WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_full <= 1'b1;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  // Payload carries no state meaning; only the full flag needs reset.
  always_ff @(posedge clock) begin
    if (i_wr) begin
      r_data <= i_wdata;
    end
  end

  assign o_rdata = r_data;
  assign o_full  = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sqd detector: words arrive over
// valid/ready and leave one bit per clock on serial_x, optionally with idle gaps.
module bit_serializer
  import sqd_pkg::*;
#(
  parameter int WIDTH     = SQD_WORD_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_x,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gcnt;

  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_gap_done;
  logic             w_reload;
  logic             w_direct;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic [WIDTH-1:0] w_next_word;
  logic [WIDTH-1:0] w_shifted;
  logic             w_cur_bit;

  assign w_accept   = data_valid && !w_hold_full;
  assign w_last_bit = (r_state == SER_SHIFT) && (r_cnt == CNT_LAST);
  assign w_gap_done = (r_state == SER_GAP) && (r_gcnt == GAP_LAST);

  // Edge at which a new word may enter the shifter directly after a frame or gap.
  assign w_reload = (w_last_bit && (GAP == 0)) || w_gap_done;

  // A word accepted when the shifter is free bypasses the holding register.
  assign w_direct    = w_accept && ((r_state == SER_IDLE) || w_reload);
  assign w_hold_wr   = w_accept && !w_direct;
  assign w_hold_rd   = w_hold_full && w_reload;
  assign w_next_word = w_hold_full ? w_hold_data : data_in;

  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  assign w_cur_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  bit_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock  (clock),
    .reset  (reset),
    .i_wr   (w_hold_wr),
    .i_wdata(data_in),
    .i_rd   (w_hold_rd),
    .o_rdata(w_hold_data),
    .o_full (w_hold_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SER_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= '0;
            r_state <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (r_cnt != CNT_LAST) begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt + CW'(1);
          end else if (GAP != 0) begin
            r_gcnt  <= '0;
            r_state <= SER_GAP;
          end else if (w_hold_full || w_accept) begin
            r_shift <= w_next_word;
            r_cnt   <= '0;
          end else begin
            r_state <= SER_IDLE;
          end
        end
        SER_GAP: begin
          if (r_gcnt != GAP_LAST) begin
            r_gcnt <= r_gcnt + 4'd1;
          end else if (w_hold_full || w_accept) begin
            r_shift <= w_next_word;
            r_cnt   <= '0;
            r_state <= SER_SHIFT;
          end else begin
            r_state <= SER_IDLE;
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  assign data_ready  = !w_hold_full;
  assign bit_valid   = (r_state == SER_SHIFT);
  assign serial_x    = bit_valid ? w_cur_bit : IDLE_BIT;
  assign frame_start = bit_valid && (r_cnt == '0);
  assign frame_last  = w_last_bit;
  assign busy        = (r_state != SER_IDLE) || w_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Two serializer instances (MSB-first/no gap, LSB-first/gap 2) driven with
// directed and random words; a scoreboard checks every serial cycle.
module tb_bit_serializer;
  import sqd_pkg::*;

  localparam int W = SQD_WORD_W;

  typedef struct {
    logic [W-1:0] word;
    int unsigned  acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          go = 1'b0;
  bit          go_tail = 1'b0;
  bit          done [2];
  bit          tail_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur (cycle %0d)", nm, cyc);
  endtask

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit MF = (g == 0);
    localparam int GP = (g == 0) ? 0 : 2;

    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready, serial_x, bit_valid, frame_start, frame_last, busy;
    exp_t         q[$];
    int           idx = 0;
    exp_t         cur;
    bit           have_cur = 1'b0;
    bit           have_last = 1'b0;
    int unsigned  last_cyc = 0;

    bit_serializer #(
      .WIDTH(W), .MSB_FIRST(MF), .IDLE_BIT(1'b0), .GAP(GP)
    ) dut (
      .clock(clk), .reset(rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .serial_x(serial_x), .bit_valid(bit_valid),
      .frame_start(frame_start), .frame_last(frame_last), .busy(busy)
    );

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] w, input bit scramble);
      logic [W-1:0] held;
      bit           take;
      data_valid = 1'b1;
      data_in    = w;
      for (int k = 0; k < 200; k++) begin
        take = data_ready;
        held = data_in;
        @(posedge clk);
        #1;
        if (take) begin
          q.push_back('{held, cyc});
          data_valid = 1'b0;
          return;
        end
        if (scramble) data_in = W'($urandom);
      end
      data_valid = 1'b0;
      fail_now($sformatf("L%0d accept", g));
    endtask

    task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    initial begin : drv
      wait (go);
      @(posedge clk);
      #1;
      if (g == 0) begin
        send(6'b101100, 1'b0);
        idle(12);
        send(6'b111000, 1'b0);
        send(6'b010101, 1'b0);
      end else begin
        send(6'b000011, 1'b0);
        idle(12);
        send(6'b110011, 1'b0);
        send(6'b101010, 1'b0);
      end
      idle(15);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        send(W'($urandom), $urandom_range(0, 1) == 1);
      end
      done[g] = 1'b1;
      wait (go_tail);
      @(posedge clk);
      #1;
      send(6'b110110, 1'b0);
      tail_done[g] = 1'b1;
    end

    always @(negedge clk) begin : mon
      int unsigned exp_start;
      int          bpos;
      if (rst) begin
        q.delete();
        idx = 0;
        have_cur = 1'b0;
        have_last = 1'b0;
      end else begin
        if (bit_valid) begin
          if (idx == 0) begin
            if (q.size() == 0) begin
              fail_now($sformatf("L%0d expected word for frame", g));
              have_cur = 1'b0;
            end else begin
              cur = q.pop_front();
              have_cur = 1'b1;
              exp_start = have_last ? umax(last_cyc + GP + 1, cur.acc) : cur.acc;
              check($sformatf("L%0d frame start cycle", g), cyc, exp_start);
            end
          end
          if (have_cur) begin
            bpos = MF ? (W - 1 - idx) : idx;
            check($sformatf("L%0d serial_x bit %0d", g, idx), serial_x, cur.word[bpos]);
          end
          check($sformatf("L%0d frame_start", g), frame_start, idx == 0);
          check($sformatf("L%0d frame_last", g), frame_last, idx == W - 1);
          check($sformatf("L%0d busy in frame", g), busy, 1'b1);
          idx++;
          if (idx == W) begin
            idx = 0;
            have_last = 1'b1;
            last_cyc = cyc;
          end
        end else begin
          check($sformatf("L%0d frame interrupted", g), idx, 0);
          check($sformatf("L%0d idle serial_x", g), serial_x, 1'b0);
          check($sformatf("L%0d idle frame flags", g), {frame_start, frame_last}, 2'b00);
          check($sformatf("L%0d busy idle", g), busy,
                (q.size() != 0) || (have_last && (cyc <= last_cyc + GP)));
        end
        check($sformatf("L%0d data_ready", g), data_ready, q.size() == 0);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, " L0 data_ready"}, lane[0].data_ready, 1'b1);
    check({tag, " L0 serial_x"}, lane[0].serial_x, 1'b0);
    check({tag, " L0 bit_valid"}, lane[0].bit_valid, 1'b0);
    check({tag, " L0 busy"}, lane[0].busy, 1'b0);
    check({tag, " L1 data_ready"}, lane[1].data_ready, 1'b1);
    check({tag, " L1 serial_x"}, lane[1].serial_x, 1'b0);
    check({tag, " L1 bit_valid"}, lane[1].bit_valid, 1'b0);
    check({tag, " L1 busy"}, lane[1].busy, 1'b0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    #10;
    check_idle_outputs("in reset");
    #20;
    rst = 1'b0;
    #2;
    check_idle_outputs("after reset");
    go = 1'b1;

    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (done[0] && done[1]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) fail_now("random phase done");

    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (lane[0].q.size() == 0 && lane[0].idx == 0 &&
          lane[1].q.size() == 0 && lane[1].idx == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("stream drained");

    go_tail = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (tail_done[0] && tail_done[1] && lane[0].idx >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("tail word in flight");
    @(posedge clk);
    #2;
    check("pre-reset L0 bit_valid", lane[0].bit_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid-word reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_idle_outputs("after mid-word reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
